dkong_dma: RTL and testbench

Two-channel memory-to-memory DMA controller for the Donkey Kong main board, answering the CPU-side DMA select (7800H–783FH). It is a subset of the i8257: channel 0 is source, channel 1 is destination. After programming, a rising edge on DRQ makes it request the Z80 bus and copy a sprite block, typically 6900H to object RAM 7000H, then release the bus and flag terminal count.

---
 rtl/dkong_dma.sv | 144 ++++++++++++++
 tb/tb_dkong_dma.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dkong_dma.sv
// dkong_dma: two-channel i8257-subset memory-to-memory DMA (ch0 source, ch1 destination); DKONG_DMA_AUTOLOAD_EN adds shadow reload
module dkong_dma #(
  parameter int CLKS_PER_BYTE = 4
) (
  input  logic        I_CLK,
  input  logic        I_RESET_n,
  input  logic        I_CS_n,
  input  logic        I_RD_n,
  input  logic        I_WR_n,
  input  logic [3:0]  I_A,
  input  logic [7:0]  I_D,
  output logic [7:0]  O_D,
  input  logic        I_DRQ,
  output logic        O_BUSRQ_n,
  input  logic        I_BUSAK_n,
  output logic [15:0] O_AB,
  output logic [7:0]  O_DB,
  input  logic [7:0]  I_DB,
  output logic        O_MRD_n,
  output logic        O_MWR_n,
  output logic        O_BUS_OE,
  output logic        O_TC,
  output logic        O_BUSY
);
  typedef enum logic [2:0] {IDLE, REQ, RD1, RD2, WR1, WR2, REL} state_t;
  state_t state_q, state_d;
  logic [2:0] drq_q;
  logic rd_n_q, wr_n_q, ff_q, en_q, tc_q;
  logic [7:0] data_q;
  logic [1:0][15:0] addr_q, cnt_q;
`ifdef DKONG_DMA_AUTOLOAD_EN
  logic auto_q, reload_q;
  logic [1:0][15:0] addr_sh_q, cnt_sh_q;
`endif
  logic rd_acc, wr_acc, chan_sel, stat_sel, last, busy, drq_rise, rd_phase, wr_phase;
  logic [15:0] rd_word;
  logic [3:0] bsel;

  if (CLKS_PER_BYTE != 4) begin : g_cfg_chk
    $error("CLKS_PER_BYTE must be 4");
  end

  assign bsel = {ff_q, 3'b000};
  assign chan_sel = I_A[3:2] == 2'b00;
  assign stat_sel = I_A == 4'h8;
  assign rd_acc = !I_CS_n && !I_RD_n && rd_n_q;
  assign wr_acc = !I_CS_n && !I_WR_n && wr_n_q;
  assign last = cnt_q[1][13:0] == 14'd0;
  assign busy = state_q != IDLE;
  assign drq_rise = drq_q[1] && !drq_q[2];
  assign rd_phase = state_q == RD1 || state_q == RD2;
  assign wr_phase = state_q == WR1 || state_q == WR2;
  assign rd_word = I_A[0] ? cnt_q[I_A[1]] : addr_q[I_A[1]];
  assign O_D = (!I_CS_n && !I_RD_n) ? (chan_sel ? rd_word[bsel +: 8] : stat_sel ? {3'b000, busy, 3'b000, tc_q} : 8'h00) : 8'h00;
  assign O_BUS_OE = rd_phase || wr_phase;
  assign O_BUSRQ_n = !(state_q == REQ || O_BUS_OE);
  assign O_MRD_n = !rd_phase;
  assign O_MWR_n = !wr_phase;
  assign O_AB = rd_phase ? addr_q[0] : wr_phase ? addr_q[1] : 16'h0000;
  assign O_DB = wr_phase ? data_q : 8'h00;
  assign O_TC = state_q == WR2 && en_q && last;
  assign O_BUSY = busy;

  // transfer sequencer state register
  always_ff @(posedge I_CLK or negedge I_RESET_n)
    if (!I_RESET_n) state_q <= IDLE;
    else state_q <= state_d;

  // next state: one byte is RD1-RD2-WR1-WR2, leave after the last byte or when disabled
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = (drq_rise && en_q) ? REQ : IDLE;
      REQ:  state_d = !I_BUSAK_n ? RD1 : REQ;
      RD1:  state_d = RD2;
      RD2:  state_d = WR1;
      WR1:  state_d = WR2;
      WR2:  state_d = (!en_q || last) ? REL : RD1;
      default: state_d = IDLE;
    endcase
  end

  // CPU register file, DRQ synchroniser and transfer datapath
  always_ff @(posedge I_CLK or negedge I_RESET_n)
    if (!I_RESET_n) begin
      drq_q <= '0;
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      ff_q <= 1'b0;
      en_q <= 1'b0;
      tc_q <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
`ifdef DKONG_DMA_AUTOLOAD_EN
      auto_q <= 1'b0;
      reload_q <= 1'b0;
      addr_sh_q <= '0;
      cnt_sh_q <= '0;
`endif
    end else begin
      drq_q <= {drq_q[1:0], I_DRQ};
      rd_n_q <= I_RD_n;
      wr_n_q <= I_WR_n;
      if (rd_acc && stat_sel) tc_q <= 1'b0;
      if (wr_acc && stat_sel) begin
        en_q <= I_D[0];
        ff_q <= 1'b0;
`ifdef DKONG_DMA_AUTOLOAD_EN
        auto_q <= I_D[7];
`endif
      end else if (chan_sel && ((wr_acc && !busy) || rd_acc)) ff_q <= !ff_q;
      if (wr_acc && chan_sel && !busy) begin
        if (I_A[0]) cnt_q[I_A[1]][bsel +: 8] <= I_D;
        else addr_q[I_A[1]][bsel +: 8] <= I_D;
`ifdef DKONG_DMA_AUTOLOAD_EN
        if (I_A[0]) cnt_sh_q[I_A[1]][bsel +: 8] <= I_D;
        else addr_sh_q[I_A[1]][bsel +: 8] <= I_D;
`endif
      end
      if (state_q == RD2) data_q <= I_DB;
      if (state_q == WR2) begin
        addr_q[0] <= addr_q[0] + 16'd1;
        addr_q[1] <= addr_q[1] + 16'd1;
        if (en_q && !last) begin
          cnt_q[0][13:0] <= cnt_q[0][13:0] - 14'd1;
          cnt_q[1][13:0] <= cnt_q[1][13:0] - 14'd1;
        end
        if (en_q && last) begin
          tc_q <= 1'b1;
`ifdef DKONG_DMA_AUTOLOAD_EN
          reload_q <= auto_q;
`endif
        end
      end
`ifdef DKONG_DMA_AUTOLOAD_EN
      if (state_q == REL && reload_q) begin
        addr_q <= addr_sh_q;
        cnt_q <= cnt_sh_q;
        reload_q <= 1'b0;
      end
`endif
    end
endmodule

// File: tb/tb_dkong_dma.sv
// tb_dkong_dma: scoreboard bench for dkong_dma with a source-memory and bus-grant model
module tb_dkong_dma;
  logic I_CLK = 0, I_RESET_n = 0, I_CS_n = 1, I_RD_n = 1, I_WR_n = 1, I_DRQ = 0, I_BUSAK_n = 1;
  logic [3:0] I_A = 0;
  logic [7:0] I_D = 0, O_D, O_DB, I_DB, rd;
  logic [15:0] O_AB;
  logic O_BUSRQ_n, O_MRD_n, O_MWR_n, O_BUS_OE, O_TC, O_BUSY;
  logic [23:0] exp_q[$];
  int n_chk = 0, n_pass = 0, wr_cnt = 0, tc_cnt = 0, oe_cnt = 0, rq_cnt = 0;
  logic mwr_prev = 1;

  dkong_dma #(.CLKS_PER_BYTE(4)) dut (
    .I_CLK(I_CLK), .I_RESET_n(I_RESET_n), .I_CS_n(I_CS_n), .I_RD_n(I_RD_n), .I_WR_n(I_WR_n),
    .I_A(I_A), .I_D(I_D), .O_D(O_D), .I_DRQ(I_DRQ), .O_BUSRQ_n(O_BUSRQ_n), .I_BUSAK_n(I_BUSAK_n),
    .O_AB(O_AB), .O_DB(O_DB), .I_DB(I_DB), .O_MRD_n(O_MRD_n), .O_MWR_n(O_MWR_n),
    .O_BUS_OE(O_BUS_OE), .O_TC(O_TC), .O_BUSY(O_BUSY)
  );

  always #5 I_CLK = ~I_CLK;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return (a[7:0] ^ 8'h5A) + a[15:8];
  endfunction

  assign I_DB = !O_MRD_n ? mem_f(O_AB) : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // CPU grants the bus one beat after the request
  always @(posedge I_CLK) begin
    #1 I_BUSAK_n = O_BUSRQ_n;
  end

  // write monitor: pop the scoreboard on each DMA write, count TC/OE/request cycles
  always @(negedge I_CLK) begin
    if (I_RESET_n) begin
      if (!O_MWR_n && mwr_prev) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("sb_extra", exp_q.size(), 1);
        else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", O_AB, e[23:8]);
          chk("wr_data", O_DB, e[7:0]);
        end
      end
      if (O_TC) begin
        tc_cnt++;
        chk("tc_on_last", exp_q.size(), 0);
      end
      if (O_BUS_OE) oe_cnt++;
      if (!O_BUSRQ_n) rq_cnt++;
    end
    mwr_prev = O_MWR_n;
  end

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge I_CLK); I_A = a; I_D = d; I_CS_n = 0; I_WR_n = 0;
    @(negedge I_CLK); I_CS_n = 1; I_WR_n = 1;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge I_CLK); I_A = a; I_CS_n = 0; I_RD_n = 0;
    #1 d = O_D;
    @(negedge I_CLK); I_CS_n = 1; I_RD_n = 1;
  endtask

  task automatic prog(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] cnt, input logic [7:0] mode);
    cpu_wr(4'h8, 8'h00);
    cpu_wr(4'h0, src[7:0]); cpu_wr(4'h0, src[15:8]);
    cpu_wr(4'h2, dst[7:0]); cpu_wr(4'h2, dst[15:8]);
    cpu_wr(4'h3, cnt[7:0]); cpu_wr(4'h3, cnt[15:8]);
    cpu_wr(4'h1, cnt[7:0]); cpu_wr(4'h1, cnt[15:8]);
    cpu_wr(4'h8, mode);
  endtask

  task automatic push_blk(input logic [15:0] src, input logic [15:0] dst, input int n);
    for (int i = 0; i <= n; i++) exp_q.push_back({dst + 16'(i), mem_f(src + 16'(i))});
  endtask

  task automatic pulse_drq();
    @(negedge I_CLK); I_DRQ = 1;
    repeat (4) @(negedge I_CLK);
    I_DRQ = 0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!O_BUSY && n < 20) begin @(negedge I_CLK); n++; end
    chk("busy_seen", O_BUSY, 1);
    n = 0;
    while (O_BUSY && n < budget) begin @(negedge I_CLK); n++; end
    chk("busy_end", O_BUSY, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m;
    repeat (2) @(negedge I_CLK);
    chk("rst_out", {O_BUSRQ_n, O_MRD_n, O_MWR_n, O_BUS_OE, O_TC, O_BUSY}, 6'b111000);
    chk("rst_ab", O_AB, 16'h0000);
    chk("rst_db", O_DB, 8'h00);
    chk("rst_d", O_D, 8'h00);
    I_RESET_n = 1;
    // byte order and flip-flop clearing by a mode write
    cpu_wr(4'h0, 8'h00); cpu_wr(4'h0, 8'h69);
    cpu_rd(4'h0, rd); chk("bo_lo", rd, 8'h00);
    cpu_rd(4'h0, rd); chk("bo_hi", rd, 8'h69);
    cpu_wr(4'h0, 8'h34); cpu_wr(4'h8, 8'h00); cpu_wr(4'h0, 8'h12); cpu_wr(4'h0, 8'h78);
    cpu_rd(4'h0, rd); chk("ffclr_lo", rd, 8'h12);
    cpu_rd(4'h0, rd); chk("ffclr_hi", rd, 8'h78);
    // source address wrap
    prog(16'hFFFF, 16'h7000, 16'h0001, 8'h01);
    exp_q.push_back({16'h7000, mem_f(16'hFFFF)});
    exp_q.push_back({16'h7001, mem_f(16'h0000)});
    wr_cnt = 0; tc_cnt = 0;
    pulse_drq();
    wait_done(100);
    chk("wrap_bytes", wr_cnt, 2);
    chk("wrap_tc", tc_cnt, 1);
    cpu_rd(4'h0, rd); chk("wrap_a0_lo", rd, 8'h01);
    cpu_rd(4'h0, rd); chk("wrap_a0_hi", rd, 8'h00);
    cpu_rd(4'h3, rd); chk("wrap_c1_lo", rd, 8'h00);
    cpu_rd(4'h3, rd); chk("wrap_c1_hi", rd, 8'h00);
    chk("wrap_sb_left", exp_q.size(), 0);
    // sprite block copy with latency and status checks
    prog(16'h6900, 16'h7000, 16'h017F, 8'h01);
    push_blk(16'h6900, 16'h7000, 383);
    wr_cnt = 0; tc_cnt = 0; oe_cnt = 0;
    @(negedge I_CLK); I_DRQ = 1;
    n = 0;
    do begin @(negedge I_CLK); n++; end while (O_BUSRQ_n && n < 10);
    chk("drq_lat", n, 3);
    m = 0;
    do begin @(negedge I_CLK); m++; end while (O_MRD_n && m < 10);
    chk("ak_lat", m, 1);
    I_DRQ = 0;
    repeat (100) @(negedge I_CLK);
    cpu_rd(4'h8, rd); chk("stat_mid", rd, 8'h11);
    wait_done(2000);
    chk("blk_bytes", wr_cnt, 384);
    chk("blk_clocks", oe_cnt, 1536);
    chk("blk_tc", tc_cnt, 1);
    cpu_rd(4'h8, rd); chk("stat_after", rd, 8'h01);
    cpu_rd(4'h8, rd); chk("stat_clr", rd, 8'h00);
    cpu_rd(4'h0, rd); chk("blk_a0_lo", rd, 8'h80);
    cpu_rd(4'h0, rd); chk("blk_a0_hi", rd, 8'h6A);
    chk("blk_sb_left", exp_q.size(), 0);
    // abort by clearing enable after the third byte
    prog(16'h1000, 16'h2000, 16'h0009, 8'h01);
    push_blk(16'h1000, 16'h2000, 3);
    wr_cnt = 0; tc_cnt = 0;
    pulse_drq();
    n = 0;
    while (wr_cnt < 3 && n < 100) begin @(negedge I_CLK); #1; n++; end
    cpu_wr(4'h8, 8'h00);
    wait_done(100);
    chk("abort_bytes", wr_cnt, 4);
    chk("abort_tc", tc_cnt, 0);
    cpu_rd(4'h8, rd); chk("abort_stat", rd, 8'h00);
    chk("abort_sb_left", exp_q.size(), 0);
    // autoload: second DRQ repeats the block only when the reload feature is built in
    prog(16'h6900, 16'h7000, 16'h0003, 8'h81);
    push_blk(16'h6900, 16'h7000, 3);
    wr_cnt = 0;
    pulse_drq();
    wait_done(100);
`ifdef DKONG_DMA_AUTOLOAD_EN
    push_blk(16'h6900, 16'h7000, 3);
    pulse_drq();
    wait_done(100);
    chk("auto_bytes", wr_cnt, 8);
`else
    push_blk(16'h6904, 16'h7004, 0);
    pulse_drq();
    wait_done(100);
    chk("auto_bytes", wr_cnt, 5);
`endif
    chk("auto_sb_left", exp_q.size(), 0);
    // asynchronous reset during RD2
    prog(16'h3000, 16'h4000, 16'h0005, 8'h01);
    wr_cnt = 0;
    pulse_drq();
    n = 0;
    while (O_MRD_n && n < 50) begin @(negedge I_CLK); n++; end
    @(posedge I_CLK); #1;
    chk("in_rd2", O_MRD_n, 0);
    I_RESET_n = 0;
    #1;
    chk("arst_out", {O_BUSRQ_n, O_MRD_n, O_MWR_n, O_BUS_OE, O_TC, O_BUSY}, 6'b111000);
    chk("arst_ab", O_AB, 16'h0000);
    @(negedge I_CLK); I_RESET_n = 1;
    rq_cnt = 0;
    pulse_drq();
    repeat (10) @(negedge I_CLK);
    #1;
    chk("arst_no_req", rq_cnt, 0);
    chk("arst_no_wr", wr_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
